fft8_sdf_ctrl: RTL

FFT8_SDF_CTRL -- requirements
Module: fft8_sdf_ctrl

---
 rtl/fft8_pkg.sv | 21 ++
 rtl/fft8_sdf_ctrl_if.sv | 30 +++
 rtl/fft8_twiddle_rom.sv | 21 ++
 rtl/fft8_sdf_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared widths, twiddle constants and state encoding for the 8-point SDF FFT controller
package fft8_pkg;
  localparam int DW  = 24;
  localparam int LAT = 11;

  // W8^k in signed Q2.22
  localparam logic [DW-1:0] W0_RE = 24'h400000;
  localparam logic [DW-1:0] W0_IM = 24'h000000;
  localparam logic [DW-1:0] W1_RE = 24'h2D413D;
  localparam logic [DW-1:0] W1_IM = 24'hD2BEC3;
  localparam logic [DW-1:0] W2_RE = 24'h000000;
  localparam logic [DW-1:0] W2_IM = 24'hC00000;
  localparam logic [DW-1:0] W3_RE = 24'hD2BEC3;
  localparam logic [DW-1:0] W3_IM = 24'hD2BEC3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;
endpackage

// File: rtl/fft8_sdf_ctrl_if.sv
// rtl/fft8_sdf_ctrl_if.sv - sample handshake, stage selects, twiddles and output flags of the SDF controller
interface fft8_sdf_ctrl_if #(
  parameter int DW = fft8_pkg::DW
);
  logic          in_valid;
  logic          in_ready;
  logic          sel1;
  logic          sel2;
  logic          sel3;
  logic [DW-1:0] tw1_re;
  logic [DW-1:0] tw1_im;
  logic [DW-1:0] tw2_re;
  logic [DW-1:0] tw2_im;
  logic          out_valid;
  logic          out_first;
  logic          frame_err;
  logic          busy;

  modport master (
    output in_valid,
    input  in_ready, sel1, sel2, sel3, tw1_re, tw1_im, tw2_re, tw2_im,
    input  out_valid, out_first, frame_err, busy
  );

  modport slave (
    input  in_valid,
    output in_ready, sel1, sel2, sel3, tw1_re, tw1_im, tw2_re, tw2_im,
    output out_valid, out_first, frame_err, busy
  );
endinterface

// File: rtl/fft8_twiddle_rom.sv
// rtl/fft8_twiddle_rom.sv - 2-bit index to W8^idx (re, im) lookup
module fft8_twiddle_rom
  import fft8_pkg::*;
#(
  parameter int DW = fft8_pkg::DW
) (
  input  logic [1:0]    idx_i,
  output logic [DW-1:0] re_o,
  output logic [DW-1:0] im_o
);
  always_comb begin
    re_o = DW'(W0_RE);
    im_o = DW'(W0_IM);
    unique case (idx_i)
      2'd1: begin re_o = DW'(W1_RE); im_o = DW'(W1_IM); end
      2'd2: begin re_o = DW'(W2_RE); im_o = DW'(W2_IM); end
      2'd3: begin re_o = DW'(W3_RE); im_o = DW'(W3_IM); end
      default: begin re_o = DW'(W0_RE); im_o = DW'(W0_IM); end
    endcase
  end
endmodule

// File: rtl/fft8_sdf_ctrl.sv
// rtl/fft8_sdf_ctrl.sv - frame FSM, phase counter, stage selects/twiddles and valid pipe for an 8-point SDF FFT
module fft8_sdf_ctrl
  import fft8_pkg::*;
#(
  parameter int DW  = fft8_pkg::DW,
  parameter int LAT = fft8_pkg::LAT
) (
  input logic            clk,
  input logic            rst,
  fft8_sdf_ctrl_if.slave bus
);
  state_e         state_q, state_d;
  logic [2:0]     ph_q, ph_d, cnt_q, cnt_d;
  logic [1:0]     k2;
  logic [LAT-1:0] vpipe_q, vpipe_d, fpipe_q, fpipe_d;
  logic [LAT-2:0] keep;
  logic           accept, abort, active;
  logic [1:0]     tw1_idx, tw2_idx;
  logic [DW-1:0]  rom1_re, rom1_im, rom2_re, rom2_im;
  logic           in_ready_q, busy_q, sel1_q, sel2_q, sel3_q, frame_err_q;
  logic [DW-1:0]  tw1_re_q, tw1_im_q, tw2_re_q, tw2_im_q;

  always_comb begin
    accept = bus.in_valid && in_ready_q;
    abort  = (state_q == ST_RUN) && !bus.in_valid;
    // On abort the current frame's samples occupy the low cnt_q pipe bits
    keep    = abort ? ~(((LAT-1)'(1) << cnt_q) - (LAT-1)'(1)) : '1;
    vpipe_d = {vpipe_q[LAT-2:0] & keep, accept};
    fpipe_d = {fpipe_q[LAT-2:0] & keep, accept && (cnt_q == 3'd0)};

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          cnt_d   = 3'd1;
        end
      end
      ST_RUN: begin
        if (!bus.in_valid) begin
          state_d = ST_GAP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = 3'd1;
        end else if (vpipe_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active = (state_d != ST_IDLE);
    ph_d   = active ? ph_q + 3'd1 : 3'd0;
    // ph_q is (t-1) mod 8 for the output cycle t; k1 = k3 = ph_q, k2 mod 4 = ph_q + 3
    k2      = ph_q[1:0] + 2'd3;
    tw1_idx = (!active || ph_q[2]) ? 2'd0 : ph_q[1:0];
    tw2_idx = (!active || k2[1]) ? 2'd0 : {k2[0], 1'b0};
  end

  fft8_twiddle_rom #(.DW(DW)) u_rom1 (.idx_i(tw1_idx), .re_o(rom1_re), .im_o(rom1_im));
  fft8_twiddle_rom #(.DW(DW)) u_rom2 (.idx_i(tw2_idx), .re_o(rom2_re), .im_o(rom2_im));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ph_q        <= 3'd0;
      cnt_q       <= 3'd0;
      vpipe_q     <= '0;
      fpipe_q     <= '0;
      sel1_q      <= 1'b0;
      sel2_q      <= 1'b0;
      sel3_q      <= 1'b0;
      tw1_re_q    <= DW'(W0_RE);
      tw1_im_q    <= DW'(W0_IM);
      tw2_re_q    <= DW'(W0_RE);
      tw2_im_q    <= DW'(W0_IM);
      frame_err_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      vpipe_q     <= vpipe_d;
      fpipe_q     <= fpipe_d;
      sel1_q      <= active & ph_q[2];
      sel2_q      <= active & k2[1];
      sel3_q      <= active & ph_q[0];
      tw1_re_q    <= rom1_re;
      tw1_im_q    <= rom1_im;
      tw2_re_q    <= rom2_re;
      tw2_im_q    <= rom2_im;
      frame_err_q <= abort;
      in_ready_q  <= (state_d != ST_GAP) || (ph_d == 3'd0);
      busy_q      <= active;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.sel1      = sel1_q;
  assign bus.sel2      = sel2_q;
  assign bus.sel3      = sel3_q;
  assign bus.tw1_re    = tw1_re_q;
  assign bus.tw1_im    = tw1_im_q;
  assign bus.tw2_re    = tw2_re_q;
  assign bus.tw2_im    = tw2_im_q;
  assign bus.frame_err = frame_err_q;
  assign bus.out_valid = vpipe_q[LAT-1];
  assign bus.out_first = vpipe_q[LAT-1] & fpipe_q[LAT-1];
endmodule
